vmult_lane_seq: RTL
===================

Name: vmult_lane_seq

Overview:
- Sequencer for vector multiply. Accepts two packed vectors of half-precision (binary16) elements and streams them lane by lane through one instance of the existing combinational half-precision multiplier, VMULT (ports: product, Overflow, A, B).
- Registers each lane's product and overflow flag into a packed result vector, then signals completion.
- Sits between the vector register file read port and the writeback stage of the vector unit.

Parameters:
- LANES, 16, number of 16-bit elements per vector.
- EW, 16, element width in bits. Fixed at 16 to match VMULT.
- CW, 5, width of the vlen and lane-counter fields; must satisfy 2^CW > LANES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request pulse. Sampled only in IDLE.
- vlen  input  CW  active lane count. 0 and any value above LANES are treated as LANES.
- vecA  input  LANES*EW  operand A; lane i is bits [i*EW +: EW].
- vecB  input  LANES*EW  operand B, packed like vecA.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.
- result  output  LANES*EW  packed products.
- ovf_lanes  output  LANES  per-lane overflow flag from VMULT.
- ovf  output  1  OR of ovf_lanes.

Behaviour:
- Reset, asynchronous: state=IDLE; busy=0, done=0, result=0, ovf_lanes=0, ovf=0; lane counter=0; operand registers=0.
- Reset asserted mid-operation aborts the operation. No done pulse is produced and all outputs clear immediately.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - latch vecA, vecB and the effective vlen (n) into internal registers;
  - clear result and ovf_lanes;
  - counter=0; next state RUN.
- IDLE, start=0: outputs hold their previous values.
- RUN, combinational path: the multiplier is driven with A=opA[counter], B=opB[counter].
- RUN, each edge: result[counter] <= product; ovf_lanes[counter] <= Overflow. Then:
  - if counter==n-1: next state DONE;
  - otherwise counter increments.
- DONE: done=1 for exactly one cycle; next state IDLE.
- Latency: let E0 be the edge that samples start. Lane k is written at edge E(k+1). done is high during the cycle after edge En. busy is high from after E0 through the DONE cycle.
- start during RUN or DONE is ignored. Input vectors may change after E0 without affecting the operation in progress.
- Lanes at index n and above stay 0 in result and ovf_lanes.
- result, ovf_lanes and ovf stay stable from done until the next accepted start.
- ovf is combinational from the ovf_lanes register; no extra latency.
- No arithmetic is performed outside VMULT. Sign, rounding, subnormal handling and overflow encoding are exactly as VMULT produces them.
- Counter width is CW. It never exceeds LANES-1 and has no wrap-around.

Test Plan:
- vlen=16, every lane A=3C00 and B=3C00 -> done pulses 16 edges after the start edge; every result lane = 3C00; ovf=0; busy high for 17 cycles.
- vlen=3, lane0 A=BC00 B=3C00, lane1 A=BC00 B=BC00, lane2 A=4080 B=0201 -> result lanes 0..2 = BC00, 3C00, 0482; lanes 3..15 = 0000; done 3 edges after start.
- vlen=2, lane1 A=7AAA B=7ADE -> result lane1 = 7C00; ovf_lanes=16'h0002; ovf=1. On the next start with benign operands, ovf clears at the start edge.
- vlen=4, start re-pulsed during RUN and vecA changed at E1 -> a single done pulse; results computed from the operands latched at E0.
- vlen=0 and vlen=20 -> both behave as 16 lanes; done occurs 16 edges after start.
- vlen=8, rst raised after 3 lanes written -> result=0 and busy=0 immediately, no done pulse. A fresh start after rst is released completes normally.

Source files
------------

// File: rtl/vmult_lane_seq.sv
// Vector multiply sequencer: streams binary16 lanes through one shared VMULT
// and collects products and overflow flags into packed result registers.

module VMULT (
    output logic [15:0] product,
    output logic        Overflow,
    input  logic [15:0] A,
    input  logic [15:0] B
);
    logic              w_sign;
    logic [4:0]        w_ea_eff, w_eb_eff, w_lz, w_rsh, w_ef;
    logic [10:0]       w_sa, w_sb;
    logic [21:0]       w_p, w_pn;
    logic signed [7:0] w_exp, w_rsh_s;
    logic [45:0]       w_ext;
    logic              w_sticky, w_inc;
    logic [14:0]       w_mag;
    logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

    function automatic logic [4:0] lzc22(input logic [21:0] v);
        logic [4:0] n;
        n = 5'd22;
        for (int i = 0; i < 22; i++) begin
            n = v[i] ? 5'(21 - i) : n;
        end
        return n;
    endfunction

    // Significand multiply, normalise, denormalise below emin, round to nearest even.
    always_comb begin
        w_sign   = A[15] ^ B[15];
        w_ea_eff = (A[14:10] == 5'd0) ? 5'd1 : A[14:10];
        w_eb_eff = (B[14:10] == 5'd0) ? 5'd1 : B[14:10];
        w_sa     = {(A[14:10] != 5'd0), A[9:0]};
        w_sb     = {(B[14:10] != 5'd0), B[9:0]};
        w_a_zero = (A[14:0] == 15'd0);
        w_b_zero = (B[14:0] == 15'd0);
        w_a_inf  = (A[14:10] == 5'd31) && (A[9:0] == 10'd0);
        w_b_inf  = (B[14:10] == 5'd31) && (B[9:0] == 10'd0);
        w_a_nan  = (A[14:10] == 5'd31) && (A[9:0] != 10'd0);
        w_b_nan  = (B[14:10] == 5'd31) && (B[9:0] != 10'd0);

        w_p     = 22'(w_sa) * 22'(w_sb);
        w_lz    = lzc22(w_p);
        w_pn    = w_p << w_lz;
        w_exp   = $signed({3'b000, w_ea_eff}) + $signed({3'b000, w_eb_eff})
                - 8'sd14 - $signed({3'b000, w_lz});
        w_rsh_s = 8'sd1 - w_exp;
        if (w_exp < 8'sd1) begin
            w_rsh = (w_rsh_s > 8'sd25) ? 5'd25 : 5'(w_rsh_s);
        end else begin
            w_rsh = 5'd0;
        end
        // Bit 45 keeps the hidden one only when the result stays normal.
        w_ext    = {w_pn, 24'd0} >> w_rsh;
        w_ef     = w_ext[45] ? 5'(w_exp) : 5'd0;
        w_sticky = |w_ext[33:0];
        w_inc    = w_ext[34] & (w_sticky | w_ext[35]);
        w_mag    = {w_ef, w_ext[44:35]} + {14'd0, w_inc};

        product  = {w_sign, w_mag};
        Overflow = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            product = 16'h7E00;
        end else if (w_a_inf || w_b_inf) begin
            product = {w_sign, 15'h7C00};
        end else if (w_p == 22'd0) begin
            product = {w_sign, 15'h0000};
        end else if ((w_exp > 8'sd30) || (w_mag[14:10] == 5'd31)) begin
            product  = {w_sign, 15'h7C00};
            Overflow = 1'b1;
        end else begin
            product = {w_sign, w_mag};
        end
    end
endmodule

module vmult_lane_seq #(
    parameter int LANES = 16,
    parameter int EW    = 16,
    parameter int CW    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CW-1:0]       vlen,
    input  logic [LANES*EW-1:0] vecA,
    input  logic [LANES*EW-1:0] vecB,
    output logic                busy,
    output logic                done,
    output logic [LANES*EW-1:0] result,
    output logic [LANES-1:0]    ovf_lanes,
    output logic                ovf
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt, r_last, w_last;
    logic [LANES*EW-1:0] r_opa, r_opb, r_result;
    logic [LANES-1:0]    r_ovf_lanes;
    logic                r_busy, r_done;
    logic [EW-1:0]       w_a, w_b, w_product;
    logic                w_ovf;

    // Effective last lane index; zero or oversize vlen means a full vector.
    always_comb begin
        if ((vlen == {CW{1'b0}}) || (vlen > CW'(LANES))) begin
            w_last = CW'(LANES - 1);
        end else begin
            w_last = vlen - CW'(1);
        end
    end

    // Operand lane select for the shared multiplier.
    always_comb begin
        w_a = r_opa[int'(r_cnt)*EW +: EW];
        w_b = r_opb[int'(r_cnt)*EW +: EW];
    end

    VMULT u_vmult (
        .product  (w_product),
        .Overflow (w_ovf),
        .A        (w_a),
        .B        (w_b)
    );

    // Sequencer FSM with registered status and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CW{1'b0}};
            r_last      <= {CW{1'b0}};
            r_opa       <= {(LANES*EW){1'b0}};
            r_opb       <= {(LANES*EW){1'b0}};
            r_result    <= {(LANES*EW){1'b0}};
            r_ovf_lanes <= {LANES{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_opa       <= vecA;
                        r_opb       <= vecB;
                        r_last      <= w_last;
                        r_result    <= {(LANES*EW){1'b0}};
                        r_ovf_lanes <= {LANES{1'b0}};
                        r_cnt       <= {CW{1'b0}};
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (r_cnt == CW'(i)) begin
                            r_result[i*EW +: EW] <= w_product;
                            r_ovf_lanes[i]       <= w_ovf;
                        end
                    end
                    if (r_cnt == r_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign ovf_lanes = r_ovf_lanes;
    assign ovf       = |r_ovf_lanes;
endmodule
